wshb_arbiter: RTL and testbench

N-master to 1-slave Wishbone arbiter for the DE10-Nano graphics controller, e.g. VGA read-out and a CPU/blitter sharing the SDRAM Wishbone port.
- Round-robin grant held for a whole bus cycle (cyc), so registered-feedback bursts (cti/bte) stay atomic.
- Generalised in master count and data width.
- Adds a per-cycle watchdog that aborts a hung slave with err.

---
 rtl/wshb_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/wshb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wshb_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and Wishbone constants for the N-master to 1-slave arbiter.
//
// Contents:
//   arb_state_e  arbiter FSM state
//   CLASSIC, CONST, INCR, END   cycle type identifiers (cti)
//   LINEAR                      burst type identifier (bte)
package wshb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   localparam logic [2:0] CLASSIC = 3'b000;
   localparam logic [2:0] CONST   = 3'b001;
   localparam logic [2:0] INCR    = 3'b010;
   localparam logic [2:0] END     = 3'b111;

   localparam logic [1:0] LINEAR  = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//
// Ports:
//   req   per-requester request bits
//   last  one-hot previous winner (search starts strictly after it)
//   next  one-hot winner, all-zero when no request is pending
module rr_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] next
);

   int unsigned  shamt;
   logic [N-1:0] rot;
   logic [N-1:0] pick;

   always_comb begin
      // Rotation amount puts the slot after 'last' at bit 0.
      shamt = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (last[i]) shamt = i + 1;
      end

      // Rotate right, take the lowest set bit, rotate back left.
      rot = N'({req, req} >> shamt);

      pick = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end

      next = N'(({pick, pick} << shamt) >> N);
   end

endmodule

// File: rtl/wshb_arbiter.sv
// N-master to 1-slave Wishbone arbiter with round-robin grant held for a whole
// bus cycle and a per-cycle watchdog that terminates a hung slave with err.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we/m_adr/m_sel/m_dat_ms/m_cti/m_bte   master requests (packed)
//   m_ack/m_err/m_rty            terminations to the granted master only
//   m_dat_sm                     slave read data broadcast to all masters
//   s_*                          single slave port
//   grant                        one-hot current grant, zero when idle
module wshb_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int unsigned N_MASTERS  = 2,
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_MASTERS-1:0]              m_cyc,
   input  logic [N_MASTERS-1:0]              m_stb,
   input  logic [N_MASTERS-1:0]              m_we,
   input  logic [N_MASTERS*32-1:0]           m_adr,
   input  logic [N_MASTERS*DATA_BYTES-1:0]   m_sel,
   input  logic [N_MASTERS*8*DATA_BYTES-1:0] m_dat_ms,
   input  logic [N_MASTERS*3-1:0]            m_cti,
   input  logic [N_MASTERS*2-1:0]            m_bte,
   output logic [N_MASTERS-1:0]              m_ack,
   output logic [N_MASTERS-1:0]              m_err,
   output logic [N_MASTERS-1:0]              m_rty,
   output logic [8*DATA_BYTES-1:0]           m_dat_sm,
   output logic                              s_cyc,
   output logic                              s_stb,
   output logic                              s_we,
   output logic [31:0]                       s_adr,
   output logic [DATA_BYTES-1:0]             s_sel,
   output logic [8*DATA_BYTES-1:0]           s_dat_ms,
   output logic [2:0]                        s_cti,
   output logic [1:0]                        s_bte,
   input  logic                              s_ack,
   input  logic                              s_err,
   input  logic                              s_rty,
   input  logic [8*DATA_BYTES-1:0]           s_dat_sm,
   output logic [N_MASTERS-1:0]              grant
);

   localparam int unsigned DW   = 8 * DATA_BYTES;
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [N_MASTERS-1:0] LastInit = {1'b1, {(N_MASTERS-1){1'b0}}};

   arb_state_e           state_q;
   logic [N_MASTERS-1:0] grant_q;
   logic [N_MASTERS-1:0] last_q;
   logic [CntW-1:0]      cnt_q;
   logic [N_MASTERS-1:0] next_grant;

   // Signals of the granted master
   logic            cyc_g, stb_g, we_g;
   logic [31:0]     adr_g;
   logic [DATA_BYTES-1:0] sel_g;
   logic [DW-1:0]   dat_g;
   logic [2:0]      cti_g;
   logic [1:0]      bte_g;

   logic busy;
   logic term;
   logic wd_fire;

   rr_arbiter #(
      .N (N_MASTERS)
   ) u_rr (
      .req  (m_cyc),
      .last (last_q),
      .next (next_grant)
   );

   // AND-OR style mux; grant_q is one-hot or zero, so zero grant yields zeros.
   always_comb begin
      cyc_g = 1'b0;
      stb_g = 1'b0;
      we_g  = 1'b0;
      adr_g = '0;
      sel_g = '0;
      dat_g = '0;
      cti_g = '0;
      bte_g = '0;
      for (int i = 0; i < int'(N_MASTERS); i++) begin
         if (grant_q[i]) begin
            cyc_g = m_cyc[i];
            stb_g = m_stb[i];
            we_g  = m_we[i];
            adr_g = m_adr[32*i +: 32];
            sel_g = m_sel[DATA_BYTES*i +: DATA_BYTES];
            dat_g = m_dat_ms[DW*i +: DW];
            cti_g = m_cti[3*i +: 3];
            bte_g = m_bte[2*i +: 2];
         end
      end
   end

   assign busy = (state_q == BUSY);
   assign term = s_ack | s_err | s_rty;

   // A slave termination on the timeout cycle takes priority over the abort.
   assign wd_fire = (TIMEOUT > 0) && busy && cyc_g && stb_g && !term &&
                    (cnt_q == CntW'(TIMEOUT - 1));

   assign s_cyc    = busy & cyc_g;
   assign s_stb    = busy & stb_g;
   assign s_we     = busy & we_g;
   assign s_adr    = adr_g;
   assign s_sel    = sel_g;
   assign s_dat_ms = dat_g;
   assign s_cti    = cti_g;
   assign s_bte    = bte_g;

   assign m_ack    = busy ? (grant_q & {N_MASTERS{s_ack}})           : '0;
   assign m_err    = busy ? (grant_q & {N_MASTERS{s_err | wd_fire}}) : '0;
   assign m_rty    = busy ? (grant_q & {N_MASTERS{s_rty}})           : '0;
   assign m_dat_sm = s_dat_sm;

   assign grant = grant_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LastInit;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (|m_cyc) begin
                  grant_q <= next_grant;
                  last_q  <= next_grant;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!cyc_g) begin
                  grant_q <= '0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (wd_fire) begin
                  // Grant is kept in ABORT so the owner's cyc can be tracked.
                  cnt_q   <= '0;
                  state_q <= ABORT;
               end else if (stb_g && !term) begin
                  cnt_q <= cnt_q + CntW'(1);
               end else begin
                  cnt_q <= '0;
               end
            end
            ABORT: begin
               cnt_q <= '0;
               if (!cyc_g) begin
                  grant_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: 2 masters, 32-bit data, TIMEOUT=8.
module tb_wshb_arbiter;
   import wshb_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [63:0] m_adr;
   logic [7:0]  m_sel;
   logic [63:0] m_dat_ms;
   logic [5:0]  m_cti;
   logic [3:0]  m_bte;
   logic [1:0]  m_ack, m_err, m_rty;
   logic [31:0] m_dat_sm;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr;
   logic [3:0]  s_sel;
   logic [31:0] s_dat_ms;
   logic [2:0]  s_cti;
   logic [1:0]  s_bte;
   logic        s_ack, s_err, s_rty;
   logic [31:0] s_dat_sm;
   logic [1:0]  grant;

   int checks;
   int failures;

   wshb_arbiter #(
      .N_MASTERS  (2),
      .DATA_BYTES (4),
      .TIMEOUT    (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_cyc    (m_cyc),
      .m_stb    (m_stb),
      .m_we     (m_we),
      .m_adr    (m_adr),
      .m_sel    (m_sel),
      .m_dat_ms (m_dat_ms),
      .m_cti    (m_cti),
      .m_bte    (m_bte),
      .m_ack    (m_ack),
      .m_err    (m_err),
      .m_rty    (m_rty),
      .m_dat_sm (m_dat_sm),
      .s_cyc    (s_cyc),
      .s_stb    (s_stb),
      .s_we     (s_we),
      .s_adr    (s_adr),
      .s_sel    (s_sel),
      .s_dat_ms (s_dat_ms),
      .s_cti    (s_cti),
      .s_bte    (s_bte),
      .s_ack    (s_ack),
      .s_err    (s_err),
      .s_rty    (s_rty),
      .s_dat_sm (s_dat_sm),
      .grant    (grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      m_cyc    = '0;
      m_stb    = '0;
      m_we     = '0;
      m_adr    = '0;
      m_sel    = 8'hFF;
      m_dat_ms = 64'h2222_2222_1111_1111;
      m_cti    = '0;
      m_bte    = '0;
      s_ack    = 1'b0;
      s_err    = 1'b0;
      s_rty    = 1'b0;
      s_dat_sm = '0;

      step();
      step();
      @(negedge clk);
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_s_cyc", 64'(s_cyc), 64'h0);
      check("rst_s_stb", 64'(s_stb), 64'h0);
      check("rst_m_term", 64'({m_ack, m_err, m_rty}), 64'h0);
      step();
      rst = 1'b1;

      // Both masters request together: master 0 wins, 1-cycle latency.
      m_cyc = 2'b11;
      m_stb = 2'b11;
      m_adr = {32'h200, 32'h100};
      @(negedge clk);
      check("t1_latency_s_cyc", 64'(s_cyc), 64'h0);
      step();
      @(negedge clk);
      check("t1_grant_m0", 64'(grant), 64'h1);
      check("t1_s_cyc", 64'(s_cyc), 64'h1);
      check("t1_s_adr_m0", 64'(s_adr), 64'h100);
      step();
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      @(negedge clk);
      check("t1_drop_s_cyc", 64'(s_cyc), 64'h0);
      step();
      @(negedge clk);
      check("t1_idle_grant", 64'(grant), 64'h0);
      check("t1_idle_s_cyc", 64'(s_cyc), 64'h0);
      step();
      @(negedge clk);
      check("t1_grant_m1", 64'(grant), 64'h2);
      check("t1_s_adr_m1", 64'(s_adr), 64'h200);

      // Read ack routed to master 1 only, data broadcast.
      step();
      s_dat_sm = 32'hDEAD_BEEF;
      s_ack    = 1'b1;
      @(negedge clk);
      check("t3_m_ack", 64'(m_ack), 64'h2);
      check("t3_m_dat_sm", 64'(m_dat_sm), 64'hDEAD_BEEF);
      step();
      s_ack = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      step();

      // 4-beat INCR burst from master 0 while master 1 waits.
      m_cyc = 2'b11;
      m_stb = 2'b11;
      m_adr = {32'h200, 32'h100};
      m_cti = {3'b000, INCR};
      step();
      for (int k = 0; k < 4; k++) begin
         m_adr[31:0] = 32'h100 + 32'(4 * k);
         m_cti[2:0]  = (k == 3) ? END : INCR;
         s_ack       = 1'b1;
         @(negedge clk);
         check("t2_m_ack", 64'(m_ack), 64'h1);
         check("t2_s_adr", 64'(s_adr), 64'h100 + 64'(4 * k));
         check("t2_s_cti", 64'(s_cti), (k == 3) ? 64'h7 : 64'h2);
         check("t2_grant_held", 64'(grant), 64'h1);
         step();
      end
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      s_ack    = 1'b0;
      @(negedge clk);
      check("t2_end_s_cyc", 64'(s_cyc), 64'h0);
      step();
      @(negedge clk);
      check("t2_gap_grant", 64'(grant), 64'h0);
      step();
      @(negedge clk);
      check("t2_next_grant_m1", 64'(grant), 64'h2);
      step();
      m_cyc = '0;
      m_stb = '0;
      step();

      // Watchdog: slave never answers, err after 8 stb cycles.
      m_cyc = 2'b01;
      m_stb = 2'b01;
      m_adr = {32'h0, 32'h300};
      m_cti = '0;
      step();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         check("t4_no_err_yet", 64'(m_err), 64'h0);
         step();
      end
      @(negedge clk);
      check("t4_wd_err", 64'(m_err), 64'h1);
      check("t4_wd_s_cyc", 64'(s_cyc), 64'h1);
      step();
      @(negedge clk);
      check("t4_abort_s_cyc", 64'(s_cyc), 64'h0);
      check("t4_abort_err_pulse", 64'(m_err), 64'h0);
      check("t4_abort_grant", 64'(grant), 64'h1);
      step();
      @(negedge clk);
      check("t4_abort_hold_s_stb", 64'(s_stb), 64'h0);
      check("t4_abort_hold_ack", 64'(m_ack), 64'h0);
      step();
      m_cyc = '0;
      m_stb = '0;
      step();
      @(negedge clk);
      check("t4_abort_exit_grant", 64'(grant), 64'h0);
      step();

      // Ack on the timeout cycle wins over the watchdog.
      m_cyc = 2'b10;
      m_stb = 2'b10;
      step();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         check("t5_no_err_wait", 64'(m_err), 64'h0);
         step();
      end
      s_ack = 1'b1;
      @(negedge clk);
      check("t5_late_ack", 64'(m_ack), 64'h2);
      check("t5_late_no_err", 64'(m_err), 64'h0);
      step();
      s_ack = 1'b0;
      @(negedge clk);
      check("t5_still_busy", 64'(s_cyc), 64'h1);
      check("t5_no_err_after", 64'(m_err), 64'h0);
      step();
      m_cyc = '0;
      m_stb = '0;
      step();

      // Asynchronous reset mid-burst.
      m_cyc = 2'b01;
      m_stb = 2'b01;
      m_cti = {3'b000, INCR};
      step();
      @(negedge clk);
      check("t6_pre_s_cyc", 64'(s_cyc), 64'h1);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_s_cyc", 64'(s_cyc), 64'h0);
      check("t6_async_grant", 64'(grant), 64'h0);
      m_cyc = 2'b11;
      m_stb = 2'b11;
      step();
      rst = 1'b1;
      @(negedge clk);
      check("t6_post_rst_idle", 64'(grant), 64'h0);
      step();
      @(negedge clk);
      check("t6_first_winner_m0", 64'(grant), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
